// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared cart codes and telemetry frame builder
package cart_pkg;

    localparam logic [7:0] TELEM_HDR   = 8'hA5;
    localparam int         TELEM_BYTES = 5;

    typedef enum logic [2:0] {
        MODE_STOP  = 3'd0,
        MODE_RIGHT = 3'd1,
        MODE_LEFT  = 3'd2,
        MODE_FWD   = 3'd3,
        MODE_BACK  = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        TYPE_FOLLOW = 2'd1,
        TYPE_SPEECH = 2'd2
    } ctrl_type_t;

    // Byte 0 is sent first; byte 4 is the XOR checksum of bytes 1..3.
    typedef logic [TELEM_BYTES-1:0][7:0] telem_frame_t;

    function automatic telem_frame_t build_frame(input logic [2:0]  mode,
                                                 input logic [1:0]  ctrl_type,
                                                 input logic [19:0] distance);
        logic [15:0]  dsat;
        telem_frame_t f;
        // Distances beyond 16 bits are reported as the maximum value.
        dsat = (distance > 20'h0FFFF) ? 16'hFFFF : distance[15:0];
        f[0] = TELEM_HDR;
        f[1] = {3'b000, ctrl_type, mode};
        f[2] = dsat[15:8];
        f[3] = dsat[7:0];
        f[4] = f[1] ^ f[2] ^ f[3];
        return f;
    endfunction

endpackage

// File: rtl/uart_telemetry_tx_if.sv
// rtl/uart_telemetry_tx_if.sv - status inputs and serial outputs of the telemetry transmitter
interface uart_telemetry_tx_if;
    logic        send;
    logic        auto_en;
    logic [2:0]  mode;
    logic [1:0]  ctrl_type;
    logic [19:0] distance;
    logic        txd;
    logic        busy;
    logic        frame_done;

    modport master (
        output send, auto_en, mode, ctrl_type, distance,
        input  txd, busy, frame_done
    );

    modport slave (
        input  send, auto_en, mode, ctrl_type, distance,
        output txd, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one-byte UART serialiser with bit timer; UART_TX_PARITY_EN adds even parity
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_txd
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == LAST_CNT);
    // Ready in the last stop-bit cycle too, so the next byte follows with no gap.
    assign o_ready   = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);
    assign o_txd     = r_txd;

    // Bit-level state machine: load on start, then walk start/data/(parity)/stop bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (i_start && o_ready) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= i_data;
            r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^i_data;
`endif
        end else begin
            if ((r_state == S_IDLE) || w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            case (r_state)
                S_IDLE: r_txd <= 1'b1;
                S_START: if (w_bit_end) begin
                    r_state <= S_DATA;
                    r_txd   <= r_shift[0];
                end
                S_DATA: if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_txd   <= r_par;
`else
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
`endif
                    end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_txd   <= r_shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: if (w_bit_end) begin
                    r_state <= S_STOP;
                    r_txd   <= 1'b1;
                end
`endif
                S_STOP: if (w_bit_end) begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_telemetry_tx.sv
// rtl/uart_telemetry_tx.sv - 5-byte cart telemetry frame sender over UART; UART_TX_PARITY_EN adds even parity
module uart_telemetry_tx
    import cart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 10417,
    parameter int PERIOD_CYCLES = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    uart_telemetry_tx_if.slave bus
);

    localparam int            TW        = $clog2(PERIOD_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(TELEM_BYTES - 1);

    typedef enum logic {F_IDLE, F_RUN} fstate_t;

    fstate_t      r_state;
    telem_frame_t r_frame;
    logic [2:0]   r_idx;
    logic         r_busy;
    logic         r_frame_done;
    logic         r_pending;
    logic [TW-1:0] r_tick_cnt;

    logic       w_tick;
    logic       w_req;
    logic       w_last_byte;
    logic       w_byte_ready;
    logic       w_byte_start;
    logic [7:0] w_byte_data;
    logic       w_txd;

    assign w_tick      = bus.auto_en && (r_tick_cnt == TICK_LAST);
    assign w_req       = bus.send || w_tick || r_pending;
    assign w_last_byte = (r_idx == LAST_IDX);

    // The header is constant, so byte 0 can start in the same cycle the snapshot is taken.
    assign w_byte_start = (r_state == F_IDLE) ? w_req : (w_byte_ready && !w_last_byte);
    assign w_byte_data  = (r_state == F_IDLE) ? TELEM_HDR : r_frame[r_idx + 3'd1];

    assign bus.txd        = w_txd;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_byte_start),
        .i_data  (w_byte_data),
        .o_ready (w_byte_ready),
        .o_txd   (w_txd)
    );

    // Periodic tick counter: free-runs while auto mode is on, held at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (!bus.auto_en || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    // Frame sequencer: accept a request, snapshot status, feed bytes, flag completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= F_IDLE;
            r_frame      <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                F_IDLE: if (w_req) begin
                    r_frame   <= build_frame(bus.mode, bus.ctrl_type, bus.distance);
                    r_idx     <= '0;
                    r_busy    <= 1'b1;
                    r_pending <= 1'b0;
                    r_state   <= F_RUN;
                end
                F_RUN: begin
                    // A send while busy is dropped; a tick is remembered once.
                    if (w_tick)
                        r_pending <= 1'b1;
                    if (w_byte_ready) begin
                        if (w_last_byte) begin
                            r_state      <= F_IDLE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= F_IDLE;
            endcase
        end
    end

endmodule
